// File: rtl/animation_sequencer_pkg.sv
// Shared types and the per-animation frame-count table for the animation sequencer.
package anim_pkg;

   typedef enum logic [1:0] {
      MODE_LOOP     = 2'b00,
      MODE_PINGPONG = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   typedef enum logic {
      DirUp,
      DirDown
   } dir_e;

   localparam int unsigned DEFAULT_LIMIT = 2;

   function automatic int unsigned ani_limit(input logic [31:0] id);
      if (id == 32'd0)                        return 10;
      else if (id == 32'd1)                   return 12;
      else if (id <= 32'd6)                   return 6;
      else if (id == 32'd7)                   return 2;
      else if (id <= 32'd9)                   return 4;
      else if (id <= 32'd14)                  return 2;
      else if (id == 32'd15)                  return 4;
      else if (id == 32'd16)                  return 6;
      else if (id == 32'd17)                  return 2;
      else if (id <= 32'd22)                  return 7;
      else if (id == 32'd23)                  return 4;
      else if (id <= 32'd27)                  return 16;
      else if (id == 32'd28)                  return 32;
      else if (id == 32'd29)                  return 5;
      else if (id == 32'd30)                  return 11;
      else if (id == 32'd31)                  return 32;
      else if (id == 32'd32)                  return 5;
      else if (id == 32'd33)                  return 9;
      else if (id <= 32'd50)                  return 5;
      else                                    return DEFAULT_LIMIT;
   endfunction

endpackage

// File: rtl/animation_sequencer_if.sv
// Control and status bundle between animation-select logic and the sequencer.
interface animation_sequencer_if #(
   parameter int unsigned ANI_W   = 6,
   parameter int unsigned FRAME_W = 6,
   parameter int unsigned DIV_W   = 24
);
   logic               enable;
   logic [ANI_W-1:0]   ani_sel;
   logic               ani_load;
   logic [1:0]         mode;
   logic [DIV_W-1:0]   step_div;
   logic [ANI_W-1:0]   ani_cur;
   logic [FRAME_W-1:0] frame;
   logic [FRAME_W-1:0] limit;
   logic               frame_step;
   logic               wrap;
   logic               done;

   modport master (
      output enable, ani_sel, ani_load, mode, step_div,
      input  ani_cur, frame, limit, frame_step, wrap, done
   );

   modport slave (
      input  enable, ani_sel, ani_load, mode, step_div,
      output ani_cur, frame, limit, frame_step, wrap, done
   );
endinterface

// File: rtl/frame_limit_rom.sv
// Combinational animation ID to frame-count lookup.
module frame_limit_rom
   import anim_pkg::*;
#(
   parameter int unsigned ANI_W   = 6,
   parameter int unsigned FRAME_W = 6
) (
   input  logic [ANI_W-1:0]   id,
   output logic [FRAME_W-1:0] limit
);
   assign limit = FRAME_W'(ani_limit(32'(id)));
endmodule

// File: rtl/animation_sequencer.sv
// Frame sequencer: prescaler, frame counter and ping-pong direction FSM.
module animation_sequencer
   import anim_pkg::*;
#(
   parameter int unsigned ANI_W   = 6,
   parameter int unsigned FRAME_W = 6,
   parameter int unsigned DIV_W   = 24
) (
   input logic                  clk,
   input logic                  rst,
   animation_sequencer_if.slave bus
);
   logic [ANI_W-1:0]   ani_cur_q, ani_cur_d, rom_id;
   logic [FRAME_W-1:0] frame_q, frame_d, limit_q, rom_limit, lm1;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   dir_e               dir_q, dir_d;
   logic               frame_step_q, frame_step_d;
   logic               wrap_q, wrap_d;
   logic               done_q, done_d;
   mode_e              mode;
   logic               run, step;

   // Look up the incoming ID on a load so limit always matches ani_cur.
   assign rom_id = bus.ani_load ? bus.ani_sel : ani_cur_q;

   frame_limit_rom #(
      .ANI_W  (ANI_W),
      .FRAME_W(FRAME_W)
   ) u_rom (
      .id   (rom_id),
      .limit(rom_limit)
   );

   assign lm1  = (limit_q == '0) ? '0 : limit_q - FRAME_W'(1);
   assign mode = mode_e'(bus.mode);
   assign run  = bus.enable && (mode != MODE_HOLD) && !(mode == MODE_ONESHOT && done_q);
   assign step = run && (cnt_q >= bus.step_div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ani_cur_q    <= '0;
         frame_q      <= '0;
         limit_q      <= FRAME_W'(ani_limit(32'd0));
         cnt_q        <= '0;
         dir_q        <= DirUp;
         frame_step_q <= 1'b0;
         wrap_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         ani_cur_q    <= ani_cur_d;
         frame_q      <= frame_d;
         limit_q      <= rom_limit;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         frame_step_q <= frame_step_d;
         wrap_q       <= wrap_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      ani_cur_d    = ani_cur_q;
      frame_d      = frame_q;
      cnt_d        = cnt_q;
      dir_d        = dir_q;
      frame_step_d = 1'b0;
      wrap_d       = 1'b0;
      done_d       = done_q;

      if (mode != MODE_PINGPONG) dir_d = DirUp;

      if (bus.ani_load) begin
         ani_cur_d = bus.ani_sel;
         frame_d   = '0;
         cnt_d     = '0;
         dir_d     = DirUp;
         done_d    = 1'b0;
      end else if (run && !step) begin
         cnt_d = cnt_q + DIV_W'(1);
      end else if (step) begin
         cnt_d        = '0;
         frame_step_d = 1'b1;
         case (mode)
            MODE_LOOP: begin
               if (frame_q == lm1) begin
                  frame_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  frame_d = frame_q + FRAME_W'(1);
               end
            end
            MODE_PINGPONG: begin
               if (dir_q == DirUp) begin
                  if (frame_q != lm1) begin
                     frame_d = frame_q + FRAME_W'(1);
                  end else if (lm1 == '0) begin
                     wrap_d = 1'b1;
                  end else begin
                     dir_d   = DirDown;
                     frame_d = lm1 - FRAME_W'(1);
                     wrap_d  = (lm1 == FRAME_W'(1));
                  end
               end else if (frame_q == '0) begin
                  dir_d   = DirUp;
                  frame_d = (lm1 == '0) ? '0 : FRAME_W'(1);
               end else begin
                  frame_d = frame_q - FRAME_W'(1);
                  wrap_d  = (frame_q == FRAME_W'(1));
               end
            end
            MODE_ONESHOT: begin
               // Already parked on the last frame: just latch completion.
               if (frame_q == lm1) begin
                  frame_step_d = 1'b0;
                  done_d       = 1'b1;
                  wrap_d       = 1'b1;
               end else begin
                  frame_d = frame_q + FRAME_W'(1);
                  if (frame_q + FRAME_W'(1) == lm1) begin
                     done_d = 1'b1;
                     wrap_d = 1'b1;
                  end
               end
            end
            default: frame_step_d = 1'b0;
         endcase
      end
   end

   assign bus.ani_cur    = ani_cur_q;
   assign bus.frame      = frame_q;
   assign bus.limit      = limit_q;
   assign bus.frame_step = frame_step_q;
   assign bus.wrap       = wrap_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_animation_sequencer.sv
// Self-checking bench for animation_sequencer against a phase-based playback model.
module tb_animation_sequencer;
   localparam int unsigned ANI_W   = 6;
   localparam int unsigned FRAME_W = 6;
   localparam int unsigned DIV_W   = 24;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   animation_sequencer_if #(.ANI_W(ANI_W), .FRAME_W(FRAME_W), .DIV_W(DIV_W)) bus ();

   animation_sequencer #(.ANI_W(ANI_W), .FRAME_W(FRAME_W), .DIV_W(DIV_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: playback position within the animation's sequence plus cycles since last step.
   int m_ani, m_pos, m_cnt, e_frame;
   bit m_done, e_step, e_wrap;

   function automatic int tbl_lim(input int id);
      case (id) inside
         0:        return 10;
         1:        return 12;
         [2:6]:    return 6;
         7:        return 2;
         [8:9]:    return 4;
         [10:14]:  return 2;
         15:       return 4;
         16:       return 6;
         17:       return 2;
         [18:22]:  return 7;
         23:       return 4;
         [24:27]:  return 16;
         28:       return 32;
         29:       return 5;
         30:       return 11;
         31:       return 32;
         32:       return 5;
         33:       return 9;
         [34:50]:  return 5;
         default:  return 2;
      endcase
   endfunction

   function automatic logic [20:0] obs_vec();
      return {bus.ani_cur, bus.frame, bus.limit, bus.frame_step, bus.wrap, bus.done};
   endfunction

   function automatic logic [20:0] exp_vec();
      return {6'(m_ani), 6'(e_frame), 6'(tbl_lim(m_ani)), e_step, e_wrap, m_done};
   endfunction

   task automatic model_reset();
      m_ani = 0; m_pos = 0; m_cnt = 0; e_frame = 0;
      m_done = 0; e_step = 0; e_wrap = 0;
   endtask

   task automatic model_tick();
      int l, p;
      e_step = 0;
      e_wrap = 0;
      if (bus.ani_load) begin
         m_ani = int'(bus.ani_sel); m_pos = 0; m_cnt = 0; m_done = 0; e_frame = 0;
      end else if (bus.enable && bus.mode != 2'b11 && !(bus.mode == 2'b10 && m_done)) begin
         if (m_cnt < int'(bus.step_div)) begin
            m_cnt++;
         end else begin
            m_cnt  = 0;
            e_step = 1;
            l      = tbl_lim(m_ani);
            case (bus.mode)
               2'b00: begin
                  m_pos = (m_pos + 1) % l; e_wrap = (m_pos == 0); e_frame = m_pos;
               end
               2'b01: begin
                  if (l == 1) begin
                     e_wrap = 1; e_frame = 0;
                  end else begin
                     p = 2 * (l - 1);
                     m_pos = (m_pos + 1) % p;
                     e_wrap = (m_pos == 0);
                     e_frame = (m_pos < l) ? m_pos : p - m_pos;
                  end
               end
               default: begin
                  m_pos++; e_frame = m_pos;
                  if (m_pos == l - 1) begin
                     m_done = 1; e_wrap = 1;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic step_cycle();
      model_tick();
      @(posedge clk);
      #1;
      bus.ani_load = 1'b0;
   endtask

   task automatic load(input int sel, input logic [1:0] md, input int sd);
      bus.ani_sel  = ANI_W'(sel);
      bus.mode     = md;
      bus.step_div = DIV_W'(sd);
      bus.enable   = 1'b1;
      bus.ani_load = 1'b1;
      step_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.enable = 0; bus.ani_sel = '0; bus.ani_load = 0; bus.mode = 2'b00; bus.step_div = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== {6'd0, 6'd0, 6'd10, 3'b000}) begin
         errors++; $display("FAIL reset got %h exp %h", obs_vec(), {6'd0, 6'd0, 6'd10, 3'b000});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_loop();
      int steps = 0, wraps = 0;
      load(0, 2'b00, 2);
      for (int i = 0; i < 30; i++) begin
         step_cycle();
         steps += int'(bus.frame_step);
         wraps += int'(bus.wrap);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL loop cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (steps != 10 || wraps != 1 || bus.frame != 6'd0) begin
         errors++;
         $display("FAIL loop_count got steps=%0d wraps=%0d frame=%0d exp 10 1 0",
                  steps, wraps, bus.frame);
      end
   endtask

   task automatic test_loop32();
      bit saw31 = 0;
      int wraps = 0;
      load(28, 2'b00, 0);
      for (int i = 0; i < 40; i++) begin
         step_cycle();
         if (bus.frame == 6'd31) saw31 = 1;
         wraps += int'(bus.wrap);
         checks++;
         if (obs_vec() !== exp_vec() || bus.limit == 6'd0) begin
            errors++; $display("FAIL loop32 cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (!saw31 || wraps != 1 || bus.limit != 6'd32) begin
         errors++;
         $display("FAIL loop32_span got saw31=%0d wraps=%0d limit=%0d exp 1 1 32",
                  saw31, wraps, bus.limit);
      end
   endtask

   task automatic test_pingpong();
      int seq2[4]  = '{1, 0, 1, 0};
      int seq6[11] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
      load(7, 2'b01, 0);
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         checks++;
         if (int'(bus.frame) != seq2[i] || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pp_l2 idx%0d got frame=%0d exp %0d", i, bus.frame, seq2[i]);
         end
      end
      bus.ani_sel = 6'd2; bus.ani_load = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step_cycle();
         checks++;
         if (int'(bus.frame) != seq6[i] || bus.wrap != (i == 10) || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pp_l6 idx%0d got frame=%0d wrap=%0d exp %0d %0d",
                     i, bus.frame, bus.wrap, seq6[i], (i == 10));
         end
      end
   endtask

   task automatic test_oneshot();
      bit fin = 0;
      load(33, 2'b10, 1);
      for (int i = 0; i < 40 && !fin; i++) begin
         step_cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL oneshot cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
         fin = bus.done;
      end
      checks++;
      if (!fin || bus.frame != 6'd8 || !bus.wrap) begin
         errors++;
         $display("FAIL oneshot_end got done=%0d frame=%0d wrap=%0d exp 1 8 1",
                  bus.done, bus.frame, bus.wrap);
      end
      for (int i = 0; i < 20; i++) begin
         step_cycle();
         checks++;
         if (bus.frame != 6'd8 || bus.frame_step || bus.wrap || !bus.done) begin
            errors++; $display("FAIL oneshot_hold cyc%0d got %h exp frame 8 done", i, obs_vec());
         end
      end
      load(33, 2'b10, 1);
      checks++;
      if (bus.done || bus.frame != 6'd0) begin
         errors++; $display("FAIL oneshot_reload got done=%0d frame=%0d exp 0 0", bus.done, bus.frame);
      end
   endtask

   task automatic test_load_priority();
      bit hit = 0;
      logic [FRAME_W-1:0] f0;
      load(0, 2'b00, 1);
      for (int i = 0; i < 60 && !hit; i++) begin
         if (bus.frame == 6'd3 && m_cnt == 1) hit = 1;
         else step_cycle();
      end
      bus.ani_sel = 6'd5; bus.ani_load = 1'b1;
      step_cycle();
      checks++;
      if (!hit || bus.frame != 6'd0 || bus.frame_step || bus.ani_cur != 6'd5) begin
         errors++;
         $display("FAIL load_prio got hit=%0d frame=%0d step=%0d ani=%0d exp 1 0 0 5",
                  hit, bus.frame, bus.frame_step, bus.ani_cur);
      end
      repeat (5) step_cycle();
      for (int k = 0; k < 2; k++) begin
         f0 = bus.frame;
         if (k == 0) bus.enable = 1'b0;
         else begin bus.enable = 1'b1; bus.mode = 2'b11; end
         for (int i = 0; i < 10; i++) begin
            step_cycle();
            checks++;
            if (bus.frame != f0 || bus.frame_step || obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL freeze%0d cyc%0d got %h exp %h", k, i, obs_vec(), exp_vec());
            end
         end
      end
      bus.mode = 2'b00;
      for (int i = 0; i < 6; i++) begin
         step_cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL resume cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      bit hit = 0;
      load(2, 2'b01, 0);
      for (int i = 0; i < 30 && !hit; i++) begin
         step_cycle();
         if (bus.frame == 6'd4 && m_pos > 5) hit = 1;
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (!hit || obs_vec() !== {6'd0, 6'd0, 6'd10, 3'b000}) begin
         errors++; $display("FAIL async_rst hit=%0d got %h exp %h", hit, obs_vec(),
                            {6'd0, 6'd0, 6'd10, 3'b000});
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         step_cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL post_rst cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15) == 0) begin
            bus.ani_sel  = ANI_W'($urandom_range(63));
            bus.mode     = 2'($urandom_range(3));
            bus.step_div = DIV_W'($urandom_range(3));
            bus.ani_load = 1'b1;
         end
         bus.enable = ($urandom_range(7) != 0);
         step_cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_loop();
      test_loop32();
      test_pingpong();
      test_oneshot();
      test_load_priority();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
